// File: rtl/pipelined_divider_pkg.sv
// Shared constants for the pipelined unsigned divider.
//   DefaultWidth : default operand/quotient width used by the top and its stages.
package pipelined_divider_pkg;

  localparam int unsigned DefaultWidth = 48;

endpackage

// File: rtl/pipelined_divider_stage.sv
// One radix-2 restoring division step plus its pipeline registers.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   valid_i/o     : operation valid bit travelling with the data
//   rem_i/o       : partial remainder
//   dvd_i/o       : dividend bits not yet consumed (upper part) and quotient bits
//                   produced so far (lower part); after WIDTH stages it holds the quotient
//   dvs_i/o       : divisor
module pipelined_divider_stage
  import pipelined_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o,
  output logic [WIDTH-1:0] dvs_o
);

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic             q_bit;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] rem_d, rem_q;
  logic [WIDTH-1:0] dvd_d, dvd_q;
  logic [WIDTH-1:0] dvs_d, dvs_q;

  always_comb begin
    rem_shift = {rem_i, dvd_i[WIDTH-1]};
    // Compare at WIDTH+1 bits so the shifted-out remainder MSB is not lost.
    q_bit     = (rem_shift >= {1'b0, dvs_i});
    // When q_bit is set the true difference is below the divisor, so the low
    // WIDTH bits of the modular subtraction are exact.
    rem_sub   = rem_shift[WIDTH-1:0] - dvs_i;
    rem_d     = q_bit ? rem_sub : rem_shift[WIDTH-1:0];
    // Consumed dividend bit leaves at the top, new quotient bit enters at the bottom.
    dvd_d     = {dvd_i[WIDTH-2:0], q_bit};
    dvs_d     = dvs_i;
    valid_d   = valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
    end
  end

  assign valid_o = valid_q;
  assign rem_o   = rem_q;
  assign dvd_o   = dvd_q;
  assign dvs_o   = dvs_q;

endmodule

// File: rtl/pipelined_divider.sv
// Fully pipelined unsigned integer divider, one operation per clock.
// quotient = floor(dividend / divider), all ones when divider is zero.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset, discards in-flight operations
//   en       : operand valid, pair sampled on rising edge
//   dividend : numerator
//   divider  : denominator
//   quotient : registered result, holds last value between results
//   o_valid  : one-cycle strobe aligned with quotient, LATENCY cycles after sampling
module pipelined_divider
  import pipelined_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divider,
  output logic [WIDTH-1:0] quotient,
  output logic             o_valid
);

  // Cycles from the sampling edge to the edge that presents the result.
  localparam int unsigned LATENCY = WIDTH;

  // Index 0 is the captured input, index k+1 the output of stage k.
  logic             vld_s [LATENCY+1];
  logic [WIDTH-1:0] rem_s [LATENCY+1];
  logic [WIDTH-1:0] dvd_s [LATENCY+1];
  logic [WIDTH-1:0] dvs_s [LATENCY+1];

  logic [WIDTH-1:0] quotient_d, quotient_q;
  logic             o_valid_d, o_valid_q;

  // Bubbles enter as zeros to keep the pipeline quiet.
  always_comb begin
    vld_s[0] = en;
    rem_s[0] = '0;
    dvd_s[0] = en ? dividend : '0;
    dvs_s[0] = en ? divider : '0;
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    pipelined_divider_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst),
      .valid_i (vld_s[k]),
      .rem_i   (rem_s[k]),
      .dvd_i   (dvd_s[k]),
      .dvs_i   (dvs_s[k]),
      .valid_o (vld_s[k+1]),
      .rem_o   (rem_s[k+1]),
      .dvd_o   (dvd_s[k+1]),
      .dvs_o   (dvs_s[k+1])
    );
  end

  always_comb begin
    o_valid_d  = vld_s[LATENCY];
    quotient_d = vld_s[LATENCY] ? dvd_s[LATENCY] : quotient_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid_q  <= 1'b0;
      quotient_q <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      quotient_q <= quotient_d;
    end
  end

  assign quotient = quotient_q;
  assign o_valid  = o_valid_q;

endmodule

// File: tb/tb_pipelined_divider.sv
// Self-checking bench for pipelined_divider: a queue of expected results, each
// tagged with the edge at which it must appear, computed with plain division.
module tb_pipelined_divider;

  localparam int unsigned W = 48;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divider = '0;
  logic [W-1:0] quotient;
  logic         o_valid;

  typedef struct {
    int unsigned  due;
    logic [W-1:0] q;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipelined_divider #(
    .WIDTH (W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dividend (dividend),
    .divider  (divider),
    .quotient (quotient),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0] >> $urandom_range(0, W - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%h, expected 0x%h", tag, cyc, obs, exp);
    end
  endtask

  // Called away from the clock edge, after edge number cyc.
  task automatic check_outputs();
    if (!rst) begin
      check_eq("valid_in_reset", {{(W-1){1'b0}}, o_valid}, '0);
      check_eq("quot_in_reset", quotient, '0);
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check_eq("valid_hi", {{(W-1){1'b0}}, o_valid}, {{(W-1){1'b0}}, 1'b1});
      check_eq("quotient", quotient, exp_q[0].q);
      void'(exp_q.pop_front());
    end else begin
      check_eq("valid_lo", {{(W-1){1'b0}}, o_valid}, '0);
    end
  endtask

  // Entered at a negedge; drives one cycle of inputs and checks the outputs.
  task automatic step(input logic e, input logic [W-1:0] a, input logic [W-1:0] b);
    en       = e;
    dividend = a;
    divider  = b;
    @(posedge clk);
    cyc++;
    if (rst && e) exp_q.push_back('{due: cyc + W, q: ref_div(a, b)});
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0);
  endtask

  initial begin
    @(negedge clk);
    check_outputs();

    // Operands during reset must be ignored.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_op(), rnd_op());
    rst = 1'b1;

    step(1'b1, 48'h0003_0000_0000, 48'h0000_0001_0000);
    idle(W + 4);

    step(1'b1, 48'h0003_0000_0000, 48'h0000_0001_0000);
    step(1'b1, 48'h0002_0000_0000, 48'h0000_0001_0000);
    idle(W + 4);

    step(1'b1, 48'd7, 48'd2);
    step(1'b1, 48'd5, 48'd9);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 48'd1);
    step(1'b1, 48'h123, 48'd0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF);
    step(1'b1, 48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF);
    step(1'b1, 48'd0, 48'd0);
    idle(W + 4);

    for (int i = 0; i < 200; i++) step(1'b1, rnd_op(), rnd_op());
    idle(W + 4);

    // Mid-flight reset: three operations must never be delivered.
    step(1'b1, 48'd100, 48'd7);
    step(1'b1, 48'd200, 48'd7);
    step(1'b1, 48'd300, 48'd7);
    idle(17);
    rst = 1'b0;
    #1;
    check_eq("async_rst_valid", {{(W-1){1'b0}}, o_valid}, '0);
    check_eq("async_rst_quot", quotient, '0);
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1, rnd_op(), rnd_op());
    rst = 1'b1;
    idle(W + 10);

    // Bubble pattern 1,0,1 then random en toggling.
    step(1'b1, 48'd1000, 48'd3);
    step(1'b0, 48'd9999, 48'd1);
    step(1'b1, 48'd1001, 48'd3);
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), rnd_op(), rnd_op());
    idle(W + 4);

    check_eq("queue_drained", 48'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_divider.md
# pipelined_divider

Fully pipelined unsigned integer divider. It accepts one dividend/divisor pair per clock and returns the quotient a fixed WIDTH cycles later, with a valid strobe. It serves the ray-tracing datapath wherever a wide fixed-point or integer ratio is needed at full throughput. Results are integer quotients (truncated); any fixed-point scaling is the caller's responsibility.

## Interface
- WIDTH, default 48: bit width of dividend, divisor and quotient.
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operand valid; pair sampled on any rising edge where en=1.
- dividend  input  WIDTH  unsigned numerator.
- divider  input  WIDTH  unsigned denominator.
- quotient  output  WIDTH  unsigned floor(dividend/divider); registered.
- o_valid  output  1  high for exactly one cycle per accepted operation, aligned with quotient.

## Operation
- Radix-2 restoring long division, one quotient bit per pipeline stage, MSB first; WIDTH stages total.
- Each stage carries partial remainder (WIDTH bits), the remaining dividend bits, the divisor and a valid bit; stage k shifts remainder left by one, brings in the next dividend bit, compares against the divisor, subtracts if greater or equal, and records the quotient bit.
- Comparison/subtraction done at WIDTH+1 bits so no carry is lost.
- No back-pressure: an operation accepted is always delivered; results emerge strictly in issue order.
- en=0 cycles inject bubbles: valid bit 0 propagates; quotient output then holds its last value (no requirement on contents while o_valid=0).
- Divide by zero (divider=0): quotient = all ones (2^WIDTH-1), o_valid asserted normally; no error flag.
- dividend < divider: quotient 0.
- Reset asserted (rst=0): all valid bits, o_valid and quotient clear to 0 immediately; in-flight operations are discarded, not delivered after release.
- Operands present while rst=0 are ignored.

## Timing
- Latency: operand sampled at edge N (en=1) -> o_valid=1 and quotient correct after edge N+WIDTH (48 cycles at default).
- Throughput: one operation per cycle; en may be held high continuously.
- Back-to-back issues at edges N and N+1 produce o_valid high after edges N+WIDTH and N+WIDTH+1 with respective quotients.
- Reset values: quotient=0, o_valid=0, all internal stage registers 0.
- First sampling edge after reset release: the first rising edge where rst=1.

## Structure
- No shared package content required; a localparam LATENCY = WIDTH is exported as a module constant for callers aligning sidebands.
- One sub-module natural: divider_stage (one compare/subtract/shift step plus its pipeline registers, parameterised by WIDTH), instantiated WIDTH times via generate.
- Top level holds input capture muxing and the output register only.

## Test plan
- Reset held 10 cycles, then en pulse with 0x300000000 / 0x10000 -> o_valid one cycle after 48 edges, quotient 0x30000.
- Back-to-back: 0x300000000/0x10000 then 0x200000000/0x10000 on consecutive cycles -> consecutive o_valid, quotients 0x30000 then 0x20000.
- Edge values: 7/2 -> 3; 5/9 -> 0; 0xFFFFFFFFFFFF/1 -> 0xFFFFFFFFFFFF; 0x123/0 -> 0xFFFFFFFFFFFF.
- Streaming: en held high 200 cycles with random operands -> every result matches floor division, in order, no gaps.
- Reset mid-flight: issue 3 operations, assert rst=0 at cycle 20 -> o_valid and quotient 0 immediately; no o_valid ever appears for those operations.
- Bubbles: en toggling 1,0,1 -> o_valid pattern 1,0,1 exactly WIDTH cycles later.
